reg_bank_we: RTL

- Parametrised successor to the single-bit gated D latch: a multi-entry, multi-byte, write-enabled storage bank.
- Edge-triggered entries; one write port with byte enables; NRD registered read ports.
- Per-entry valid bits, flash invalidate, and optional write-to-read bypass.
- Used as the general architectural/scratch register store in the uarch datapath.

---
 rtl/reg_bank_pkg.sv | 21 ++
 rtl/reg_bank_entry.sv | 35 +++
 rtl/reg_bank_we.sv | 71 +++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared constants and helpers for the register bank.
package reg_bank_pkg;
    localparam int BYTE = 8;
    localparam int MAXW = 1024;
    localparam int MAXB = MAXW / BYTE;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Callers zero-extend to MAXW and truncate the result back to their width.
    function automatic logic [MAXW-1:0] byte_merge(input logic [MAXW-1:0] old_w, input logic [MAXW-1:0] new_w,
                                                   input logic [MAXB-1:0] be);
        logic [MAXW-1:0] r;
        for (int i = 0; i < MAXB; i++) r[i*BYTE +: BYTE] = be[i] ? new_w[i*BYTE +: BYTE] : old_w[i*BYTE +: BYTE];
        return r;
    endfunction
endpackage

// File: rtl/reg_bank_entry.sv
// reg_bank_entry: one byte-writable storage word with its valid bit.
module reg_bank_entry import reg_bank_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic                  inv_i,
    input  logic [WIDTH/BYTE-1:0] be_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  valid_o
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // we_i arrives already qualified, so a write always wins over invalidate.
    always_comb begin
        data_d  = we_i ? WIDTH'(byte_merge(MAXW'(data_q), MAXW'(wdata_i), MAXB'(be_i))) : data_q;
        valid_d = we_i | (valid_q & ~inv_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/reg_bank_we.sv
// reg_bank_we: multi-entry byte-enabled register bank with registered read ports,
// valid bits, flash invalidate and optional write-to-read bypass.
module reg_bank_we import reg_bank_pkg::*; #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = clog2(DEPTH) < 1 ? 1 : clog2(DEPTH),
    localparam int NB    = WIDTH / BYTE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wen,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [NB-1:0]      wbe,
    input  logic               inv_all,
    input  logic [NRD-1:0]     ren,
    input  logic [NRD*AW-1:0]  raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    output logic [NRD-1:0]     rvalid
);
    logic [WIDTH-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic             wq;

    assign wq = wen && (32'(waddr) < DEPTH) && (|wbe);

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        reg_bank_entry #(.WIDTH(WIDTH)) u_ent (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (wq && waddr == AW'(e)),
            .inv_i   (inv_all),
            .be_i    (wbe),
            .wdata_i (wdata),
            .data_o  (ent_data[e]),
            .valid_o (ent_valid[e])
        );
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]    ra;
        logic             in_rng, hit;
        logic [WIDTH-1:0] cur, rdata_d, rdata_q;
        logic             rvalid_d, rvalid_q;

        // With bypass the port sees the post-edge state of its entry.
        always_comb begin
            ra       = raddr[p*AW +: AW];
            in_rng   = 32'(ra) < DEPTH;
            hit      = (BYPASS != 0) && wq && waddr == ra;
            cur      = in_rng ? ent_data[ra] : '0;
            rdata_d  = hit ? WIDTH'(byte_merge(MAXW'(cur), MAXW'(wdata), MAXB'(wbe))) : cur;
            rvalid_d = in_rng && (hit || (ent_valid[ra] && !((BYPASS != 0) && inv_all)));
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else if (ren[p]) begin
                rdata_q  <= rdata_d;
                rvalid_q <= rvalid_d;
            end
        end

        assign rdata[p*WIDTH +: WIDTH] = rdata_q;
        assign rvalid[p]               = rvalid_q;
    end
endmodule
